// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Holds the power-on configuration (an overlapping "1010" detector, matching
// the fixed-function block this one replaces), the overlap-mode enum and a
// configuration record.
package seq_det_pkg;

    // Width the package-level default pattern and config record are sized for.
    localparam int PKG_PAT_W = 8;
    localparam int PKG_LEN_W = $clog2(PKG_PAT_W + 1);

    // Reset configuration: pattern is right-aligned, bit [len-1] arrives first.
    localparam logic [PKG_PAT_W-1:0] DEF_PAT = 8'b0000_1010;
    localparam int                   DEF_LEN = 4;
    localparam bit                   DEF_OVP = 1'b1;

    typedef enum logic {
        OVP_OFF = 1'b0,
        OVP_ON  = 1'b1
    } ovp_mode_e;

    typedef struct packed {
        logic [PKG_PAT_W-1:0] pat;
        logic [PKG_LEN_W-1:0] len;
        ovp_mode_e            ovp;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{pat: DEF_PAT, len: PKG_LEN_W'(DEF_LEN), ovp: OVP_ON};

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, forces q to 0
//   clr  - synchronous clear, wins over inc
//   inc  - count up by one unless already at MAX
//   q    - current count
module sat_counter #(
    parameter int         W   = 8,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a clear always wins, otherwise step up and stick at MAX
    // so the value never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector (Moore output).
// Watches a 1-bit stream for a pattern of 1..PAT_W bits, in overlapping or
// non-overlapping mode, and pulses out for one cycle after the last bit of
// each match. A saturating counter tallies matches since reset or cfg_load.
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   in_valid, in        - serial bit and its qualifier
//   cfg_load            - strobe latching cfg_pat/cfg_len/cfg_ovp; clears
//                         history, fill and match count; drops this cycle's bit
//   cfg_pat, cfg_len    - pattern (bit [len-1] first received) and length
//   cfg_ovp             - 1 = overlapping matches allowed
//   out                 - registered one-cycle match pulse
//   match_cnt           - saturating match count
module seq_det_param #(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = $clog2(PAT_W + 1),
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
    parameter int               DEF_LEN = seq_det_pkg::DEF_LEN,
    parameter bit               DEF_OVP = seq_det_pkg::DEF_OVP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovp,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    import seq_det_pkg::*;

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    ovp_mode_e        ovp_q, ovp_d;
    logic             out_q, out_d;

    logic [LEN_W-1:0] cfg_len_clamped;
    logic [LEN_W-1:0] fill_cnt;
    logic [PAT_W-1:0] len_mask;
    logic             accept;
    logic             fill_enough;
    logic             match;
    logic             fill_clr;

    // A configuration load takes the cycle, so any bit offered alongside it
    // is thrown away rather than shifted into the freshly cleared history.
    assign accept = in_valid & ~cfg_load;

    // Lengths beyond the shift register cannot be honoured, so they are
    // treated as a full-width pattern.
    always_comb begin
        cfg_len_clamped = cfg_len;
        if (cfg_len > LEN_W'(PAT_W)) begin
            cfg_len_clamped = LEN_W'(PAT_W);
        end
    end

    // Configuration and history next-state. History shifts left so the most
    // recent bit sits at [0], lining up with the right-aligned pattern.
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovp_d  = ovp_q;
        hist_d = hist_q;
        if (cfg_load) begin
            pat_d  = cfg_pat;
            len_d  = cfg_len_clamped;
            ovp_d  = cfg_ovp ? OVP_ON : OVP_OFF;
            hist_d = '0;
        end else if (accept) begin
            hist_d = {hist_q[PAT_W-2:0], in};
        end
    end

    // Compare against the history as it will be after this edge. Only the low
    // len_q bits take part, and enough bits must have arrived since the last
    // clear; fill is checked one ahead because the current bit is not yet in
    // the counter. Once fill saturates at PAT_W it already covers any length.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
        fill_enough = ({1'b0, fill_cnt} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
        match = accept && (len_q != '0) && fill_enough &&
                ((hist_d & len_mask) == (pat_q & len_mask));
        out_d    = match;
        fill_clr = cfg_load | (match & (ovp_q == OVP_OFF));
    end

    // State registers. Reset restores the default detector and forgets all
    // partial history so no match can straddle a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= DEF_PAT;
            len_q  <= LEN_W'(DEF_LEN);
            ovp_q  <= DEF_OVP ? OVP_ON : OVP_OFF;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovp_q  <= ovp_d;
            out_q  <= out_d;
        end
    end

    // Bits received since the last clear; in non-overlap mode a match
    // restarts it so the next match needs a full set of fresh bits.
    sat_counter #(
        .W   (LEN_W),
        .MAX (LEN_W'(PAT_W))
    ) u_fill (
        .clk (clk),
        .rst (rst),
        .clr (fill_clr),
        .inc (accept),
        .q   (fill_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (match),
        .q   (match_cnt)
    );

    assign out = out_q;

endmodule
